// File: rtl/aes256_decrypt_iter_if.sv
// Handshake and data bus of the iterative AES-256 decryptor.
// The master side (driver) loads keys and starts blocks; the slave side is the core.
interface aes256_decrypt_iter_if;
    logic         key_load;
    logic [255:0] key_i;
    logic         start;
    logic [127:0] ciphertext;
    logic         key_ready;
    logic         busy;
    logic         done;
    logic [127:0] plaintext;

    modport master (
        output key_load,
        output key_i,
        output start,
        output ciphertext,
        input  key_ready,
        input  busy,
        input  done,
        input  plaintext
    );

    modport slave (
        input  key_load,
        input  key_i,
        input  start,
        input  ciphertext,
        output key_ready,
        output busy,
        output done,
        output plaintext
    );
endinterface

// File: rtl/aes256_decrypt_iter.sv
// Iterative AES-256 inverse cipher: one key-expansion step or one cipher round per clock.
// Byte 0 of every block/key sits in the most significant byte; state is column-major.
module aes256_decrypt_iter (
    input  logic                 clk,
    input  logic                 rst,
    aes256_decrypt_iter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StKexp, StRound, StFinal} state_e;

    // GF(2^8) helpers. The S-boxes are built from the field inverse plus the affine map so
    // that no large constant table has to be maintained by hand.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p   = gf_mul(p, p);
            acc = gf_mul(acc, p);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        logic [7:0] y;
        y = x;
        for (int unsigned i = 0; i < n; i++) y = {y[6:0], y[7]};
        return y;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t;
        t = gf_inv(x);
        return t ^ rotl8(t, 1) ^ rotl8(t, 2) ^ rotl8(t, 3) ^ rotl8(t, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Row r of the state is rotated right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int b = 0; b < 16; b++) o[127-8*b -: 8] = inv_sbox(s[127-8*b -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d)
                             ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b)
                             ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e)
                             ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09)
                             ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    state_e       state_q, state_d;
    logic [3:0]   k_q, k_d;
    logic [3:0]   r_q, r_d;
    logic [127:0] s_q, s_d;
    logic [127:0] pt_q, pt_d;
    logic         done_q, done_d;
    logic         key_ready_q, key_ready_d;
    logic [127:0] rk_q [15];

    logic         rk_load;
    logic         rk_we;
    logic [127:0] rk_m1, rk_m2, kexp_rk;
    logic [31:0]  w_prev, temp, w0, w1, w2, w3;
    logic [7:0]   rcon;

    // One key-expansion step: round key k from round keys k-1 and k-2.
    // k_q stays within 2..15 at all times so both reads are always in range.
    always_comb begin
        rk_m1   = rk_q[k_q - 4'd1];
        rk_m2   = rk_q[k_q - 4'd2];
        w_prev  = rk_m1[31:0];
        rcon    = 8'h01 << (k_q[3:1] - 3'd1);
        if (!k_q[0]) temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon, 24'h0};
        else         temp = sub_word(w_prev);
        w0      = rk_m2[127:96] ^ temp;
        w1      = rk_m2[95:64]  ^ w0;
        w2      = rk_m2[63:32]  ^ w1;
        w3      = rk_m2[31:0]   ^ w2;
        kexp_rk = {w0, w1, w2, w3};
    end

    // Next-state and datapath control; key_load takes priority over start in idle.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        r_d         = r_q;
        s_d         = s_q;
        pt_d        = pt_q;
        done_d      = 1'b0;
        key_ready_d = key_ready_q;
        rk_load     = 1'b0;
        rk_we       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.key_load) begin
                    rk_load     = 1'b1;
                    k_d         = 4'd2;
                    key_ready_d = 1'b0;
                    state_d     = StKexp;
                end else if (bus.start && key_ready_q) begin
                    s_d     = bus.ciphertext ^ rk_q[14];
                    r_d     = 4'd13;
                    state_d = StRound;
                end
            end
            StKexp: begin
                // k == 15 is a closing cycle so key_ready rises 14 edges after key_load.
                if (k_q == 4'd15) begin
                    key_ready_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    rk_we = 1'b1;
                    k_d   = k_q + 4'd1;
                end
            end
            StRound: begin
                s_d = inv_mix_columns(inv_sub_bytes(inv_shift_rows(s_q)) ^ rk_q[r_q]);
                r_d = r_q - 4'd1;
                if (r_q == 4'd1) state_d = StFinal;
            end
            StFinal: begin
                pt_d    = inv_sub_bytes(inv_shift_rows(s_q)) ^ rk_q[0];
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, round-key store and result registers; reset discards keys and any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            k_q         <= 4'd2;
            r_q         <= 4'd0;
            s_q         <= '0;
            pt_q        <= '0;
            done_q      <= 1'b0;
            key_ready_q <= 1'b0;
            for (int i = 0; i < 15; i++) rk_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            r_q         <= r_d;
            s_q         <= s_d;
            pt_q        <= pt_d;
            done_q      <= done_d;
            key_ready_q <= key_ready_d;
            if (rk_load) begin
                rk_q[0] <= bus.key_i[255:128];
                rk_q[1] <= bus.key_i[127:0];
            end
            if (rk_we) rk_q[k_q] <= kexp_rk;
        end
    end

    assign bus.key_ready = key_ready_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;
    assign bus.plaintext = pt_q;

endmodule

// File: tb/tb_aes256_decrypt_iter.sv
// Directed bench for aes256_decrypt_iter using FIPS-197 and SP800-38A AES-256 vectors.
module tb_aes256_decrypt_iter;

    localparam logic [255:0] KeyC3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CtC3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PtC3  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] Key2  =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] Rk14K2 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] Ct2   = 128'h0bdf7df1591716335e9a8b15c860c502;
    localparam logic [127:0] Pt2   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    aes256_decrypt_iter_if bus ();

    aes256_decrypt_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses key_load and returns the number of edges after E0 until key_ready (40 = timeout).
    task automatic do_load(input logic [255:0] key, output int cyc);
        bus.key_i    = key;
        bus.key_load = 1'b1;
        tick();
        bus.key_load = 1'b0;
        cyc = 0;
        while (!bus.key_ready && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    // Pulses start and returns the plaintext and the edges after E0 until done (40 = timeout).
    task automatic do_decrypt(input logic [127:0] ct, output logic [127:0] pt, output int lat);
        bus.ciphertext = ct;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
        end
        pt = bus.plaintext;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.key_load   = 1'b0;
        bus.key_i      = '0;
        bus.start      = 1'b0;
        bus.ciphertext = '0;
        tick();
        tick();
        n_vec++;
        if (bus.key_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_key_ready: got %b want 0", bus.key_ready);
        end
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        n_vec++;
        if (bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_done: got %b want 0", bus.done);
        end
        n_vec++;
        if (bus.plaintext !== 128'h0) begin
            n_err++;
            $display("FAIL reset_plaintext: got %h want 0", bus.plaintext);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_c3();
        int          cyc;
        int          lat;
        logic [127:0] pt;
        do_load(KeyC3, cyc);
        n_vec++;
        if (cyc !== 14) begin
            n_err++;
            $display("FAIL c3_key_latency: got %0d want 14", cyc);
        end
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL c3_busy_after_kexp: got %b want 0", bus.busy);
        end
        do_decrypt(CtC3, pt, lat);
        n_vec++;
        if (lat !== 14) begin
            n_err++;
            $display("FAIL c3_latency: got %0d want 14", lat);
        end
        n_vec++;
        if (pt !== PtC3) begin
            n_err++;
            $display("FAIL c3_plaintext: got %h want %h", pt, PtC3);
        end
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL c3_busy_in_done: got %b want 0", bus.busy);
        end
        tick();
        n_vec++;
        if (bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL c3_done_width: got %b want 0", bus.done);
        end
        n_vec++;
        if (bus.plaintext !== PtC3) begin
            n_err++;
            $display("FAIL c3_plaintext_hold: got %h want %h", bus.plaintext, PtC3);
        end
    endtask

    task automatic test_key2();
        int          cyc;
        int          lat;
        logic [127:0] pt;
        do_load(Key2, cyc);
        n_vec++;
        if (cyc !== 14) begin
            n_err++;
            $display("FAIL k2_key_latency: got %0d want 14", cyc);
        end
        n_vec++;
        if (dut.rk_q[14] !== Rk14K2) begin
            n_err++;
            $display("FAIL k2_rk14: got %h want %h", dut.rk_q[14], Rk14K2);
        end
        do_decrypt(Ct2, pt, lat);
        n_vec++;
        if (pt !== Pt2 || lat !== 14) begin
            n_err++;
            $display("FAIL k2_plaintext: got %h lat %0d want %h lat 14", pt, lat, Pt2);
        end
        tick();
    endtask

    task automatic test_ignored_start();
        int          cyc;
        int          dones;
        logic [127:0] first_pt;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        bus.ciphertext = CtC3;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL nokey_start_busy: got %b want 0", bus.busy);
        end
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done) dones++;
        end
        n_vec++;
        if (dones !== 0 || bus.plaintext !== 128'h0) begin
            n_err++;
            $display("FAIL nokey_start_done: got %0d dones pt %h want 0 dones pt 0",
                     dones, bus.plaintext);
        end
        do_load(KeyC3, cyc);
        bus.ciphertext = CtC3;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        dones     = 0;
        first_pt  = '0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 5) begin
                bus.ciphertext = Ct2;
                bus.start      = 1'b1;
            end
            tick();
            bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                if (dones == 1) first_pt = bus.plaintext;
            end
        end
        n_vec++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL midround_start_dones: got %0d want 1", dones);
        end
        n_vec++;
        if (first_pt !== PtC3 || bus.plaintext !== PtC3) begin
            n_err++;
            $display("FAIL midround_start_pt: got %h / %h want %h",
                     first_pt, bus.plaintext, PtC3);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        int          gap;
        logic [127:0] pt;
        do_decrypt(CtC3, pt, lat);
        n_vec++;
        if (pt !== PtC3 || lat !== 14) begin
            n_err++;
            $display("FAIL b2b_first: got %h lat %0d want %h lat 14", pt, lat, PtC3);
        end
        // Second start is presented in the done cycle.
        bus.ciphertext = CtC3;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        gap = 1;
        while (!bus.done && gap < 40) begin
            tick();
            gap++;
        end
        n_vec++;
        if (gap !== 15) begin
            n_err++;
            $display("FAIL b2b_gap: got %0d want 15", gap);
        end
        n_vec++;
        if (bus.plaintext !== PtC3) begin
            n_err++;
            $display("FAIL b2b_second: got %h want %h", bus.plaintext, PtC3);
        end
        tick();
    endtask

    task automatic test_reset_mid_round();
        int          cyc;
        int          lat;
        int          dones;
        int          busys;
        logic [127:0] pt;
        bus.ciphertext = CtC3;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_vec++;
        if (dut.r_q !== 4'd7) begin
            n_err++;
            $display("FAIL rst_round_position: got r=%0d want 7", dut.r_q);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.key_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0
            || bus.plaintext !== 128'h0) begin
            n_err++;
            $display("FAIL rst_midround_outputs: got kr=%b busy=%b done=%b pt=%h want all 0",
                     bus.key_ready, bus.busy, bus.done, bus.plaintext);
        end
        n_vec++;
        if (dut.rk_q[14] !== 128'h0) begin
            n_err++;
            $display("FAIL rst_midround_rk14: got %h want 0", dut.rk_q[14]);
        end
        rst = 1'b0;
        tick();
        bus.ciphertext = CtC3;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        dones = 0;
        busys = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy) busys++;
            tick();
            if (bus.done) dones++;
        end
        n_vec++;
        if (dones !== 0 || busys !== 0) begin
            n_err++;
            $display("FAIL rst_start_ignored: got %0d dones %0d busy want 0 0", dones, busys);
        end
        do_load(KeyC3, cyc);
        do_decrypt(CtC3, pt, lat);
        n_vec++;
        if (pt !== PtC3) begin
            n_err++;
            $display("FAIL rst_reload_pt: got %h want %h", pt, PtC3);
        end
        tick();
    endtask

    task automatic test_load_start_same();
        int          cyc;
        int          dones;
        int          lat;
        logic [127:0] pt;
        bus.key_i      = Key2;
        bus.key_load   = 1'b1;
        bus.ciphertext = CtC3;
        bus.start      = 1'b1;
        tick();
        bus.key_load = 1'b0;
        bus.start    = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b1 || bus.key_ready !== 1'b0) begin
            n_err++;
            $display("FAIL same_cycle_kexp: got busy=%b kr=%b want 1 0",
                     bus.busy, bus.key_ready);
        end
        cyc   = 0;
        dones = 0;
        while (!bus.key_ready && cyc < 40) begin
            tick();
            cyc++;
            if (bus.done) dones++;
        end
        n_vec++;
        if (cyc !== 14 || dones !== 0) begin
            n_err++;
            $display("FAIL same_cycle_latency: got %0d cycles %0d dones want 14 0", cyc, dones);
        end
        do_decrypt(Ct2, pt, lat);
        n_vec++;
        if (pt !== Pt2) begin
            n_err++;
            $display("FAIL same_cycle_newkey_pt: got %h want %h", pt, Pt2);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_c3();
        test_key2();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_round();
        test_load_start_same();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes256_decrypt_iter.md
# aes256_decrypt_iter

Iterative AES-256 inverse cipher (FIPS-197 InvCipher) that complements the team's encryption datapath. A 256-bit key is loaded once and expanded internally into 15 round keys. Ciphertext blocks are then decrypted one round per clock. The block sits beside the encryption top as the block-decrypt path for verification and non-CTR use, and shares its byte ordering and key format.

## Interface
Parameters:
- none (AES-256 fixed: Nk=8, Nr=14)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- key_load  in  1  single-cycle pulse; samples key_i and starts key expansion (honoured in IDLE only)
- key_i  in  256  cipher key; bits [255:248] = key byte 0
- start  in  1  single-cycle pulse; samples ciphertext and starts decryption (honoured in IDLE with key_ready=1 only)
- ciphertext  in  128  input block; bits [127:120] = byte 0; state is column-major per FIPS-197
- key_ready  out  1  high while a fully expanded key is held
- busy  out  1  high while in KEXP, ROUND or FINAL
- done  out  1  one-cycle pulse; plaintext valid
- plaintext  out  128  result register; holds its value until the next done

## Operation
- Storage: rk[0..14], 15 x 128-bit registers. rk[k] holds words w[4k..4k+3].
- FSM states: IDLE, KEXP, ROUND, FINAL.
- IDLE + key_load:
  - rk[0] <= key_i[255:128] and rk[1] <= key_i[127:0].
  - k <= 2; key_ready <= 0; go to KEXP.
- KEXP: computes one round key per cycle, for k = 2..14 (13 cycles).
  - temp is derived from w[4k-1]:
    - k even: SubWord(RotWord(w[4k-1])) ^ {Rcon[k/2],24'h0}. Rcon = 01,02,04,08,10,20,40.
    - k odd: SubWord(w[4k-1]).
  - w[4k+j] = w[4k+j-8] ^ w[4k+j-1], with temp standing in for w[4k-1] when j=0.
  - 4 forward S-box lookups per cycle.
  - After rk[14] is written, go to IDLE with key_ready <= 1.
- IDLE + start (key_ready=1):
  - s <= ciphertext ^ rk[14]; r <= 13; go to ROUND.
- ROUND: s <= InvMixColumns(InvSubBytes(InvShiftRows(s)) ^ rk[r]); r <= r-1.
  - When r==1 is consumed, go to FINAL.
- FINAL: plaintext <= InvSubBytes(InvShiftRows(s)) ^ rk[0]; done <= 1; go to IDLE.
- Inverse S-box and InvMixColumns (GF(2^8), multipliers 0e/0b/0d/09, poly 0x11b) are combinational, 16 byte lanes.
- Boundary conditions:
  - key_load and start in the same IDLE cycle: key_load wins; start is dropped.
  - key_load or start while busy: ignored, no queuing.
  - start with key_ready=0: ignored.
  - key_load while key_ready=1: re-expands; key_ready falls on the next edge; old keys are unusable.
  - rst at any time (including mid-KEXP or mid-ROUND): IDLE, all outputs and rk cleared, key_ready=0; any partial result is discarded.

## Timing
- Reset values: key_ready=0, busy=0, done=0, plaintext=0.
- Key expansion: key_load sampled at edge E0. busy is high from E0 through E13. key_ready=1 and busy=0 after E14.
- Decryption:
  - start sampled at edge E0.
  - ROUND occupies edges E1..E13.
  - FINAL fires at E14; done=1 and plaintext valid in the cycle following E14.
  - Latency is 14 cycles start-to-done.
- Throughput: back-to-back start is accepted in the cycle done is high, giving one block per 15 cycles.
- busy is low in the done cycle.
- done is exactly one cycle wide.

## Test plan
- FIPS-197 C.3: key 000102…1f, ciphertext 8ea2b7ca516745bfeafc49904b496089 -> plaintext 00112233445566778899aabbccddeeff, done exactly 14 cycles after start.
- Key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> key_ready 14 cycles after key_load; rk[14] = fe4890d1e6188d0b046df344706c631e. Ciphertext 0bdf7df1591716335e9a8b15c860c502 -> plaintext f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff.
- start with key_ready=0, and start pulsed mid-ROUND -> no state change, no extra done, plaintext unchanged.
- Two back-to-back starts (second in the done cycle) with C.3 vectors -> two done pulses 15 cycles apart, both correct.
- rst asserted at ROUND r=7 -> all outputs 0 immediately. A following start is ignored until key_load, and after reload the C.3 result is correct.
- Same-cycle key_load+start in IDLE -> expansion runs, no done; key_ready rises 14 cycles later.
